hex_ssd_bank: RTL
=================

// Module: hex_ssd_bank
// PURPOSE
//  Parametrised multi-digit hex seven-segment driver for the DE2 HEX displays. It latches a
//  4*NDIGITS-bit value on a Load strobe and decodes each nibble to an active-low glyph.
//  It adds leading-zero blanking, per-digit enable and per-digit blink, and optional
//  time-multiplexed scanning. It sits between lab datapaths and the HEX pins, with all
//  outputs registered.
// PARAMETERS
//  NDIGITS    4           number of hex digits (1..8)
//  SCAN_MODE  0           0 = static (one SSD slice per digit); 1 = multiplexed on slice 0
//  SCAN_DIV   50000       clocks per scan step (>=2; 1 ms at 50 MHz)
//  BLINK_DIV  25000000    clocks per blink phase toggle (>=2; 0.5 s at 50 MHz)
// PORTS
//  Clock      in   1          system clock, rising edge
//  Reset      in   1          asynchronous, active-high
//  Load       in   1          capture Value/DigitEn/BlinkMask/BlankLZ this edge
//  Value      in   4*NDIGITS  hex value; nibble i -> digit i (digit 0 = least significant)
//  DigitEn    in   NDIGITS    1 = digit i may light
//  BlinkMask  in   NDIGITS    1 = digit i blinks
//  BlankLZ    in   1          1 = blank leading zero digits
//  SSD        out  7*NDIGITS  slice [7i+6:7i] = {a,b,c,d,e,f,g}, active-low
//  DigitSel   out  NDIGITS    active-low digit select (scan mode); all 0 in static mode once valid
//  Ack        out  1          one-cycle pulse: load applied to outputs
// BEHAVIOUR
//  - Reset (async): value/enable/mask/LZ regs = 0; valid = 0; counters and blink phase = 0;
//    scan index = 0; SSD = all 1s; DigitSel = all 1s; Ack = 0.
//  - Load sampled high at edge k: shadow regs captured and valid set at k.
//    SSD/DigitSel reflect the new data, and Ack = 1, from edge k+1. Ack drops at k+2
//    unless Load is high again. Back-to-back Loads are all accepted; the last one wins.
//  - Load does not disturb the blink or scan counters.
//  - Glyphs (active-low, a..g): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//    6=0100000 7=0001111 8=0000000 9=0001100 A=0001000 b=1100000 C=0110001 d=1000010
//    E=0110000 F=0111000. Blank = 1111111.
//  - Digit i is blank if any of the following holds:
//    ~valid | ~DigitEn[i] | (BlinkMask[i] & phase) | (BlankLZ & i > msd & i != 0).
//    msd = index of the highest nonzero nibble (0 if Value == 0). Digit 0 is never
//    LZ-blanked, so 0 shows as "0".
//  - Blink: a 0..BLINK_DIV-1 counter toggles phase on wrap. Phase 1 = masked digits dark.
//  - Static mode: SSD slice i = digit i pattern. DigitSel = all 0 when valid, all 1 otherwise.
//    The scan counter is held at 0.
//  - Scan mode: a 0..SCAN_DIV-1 counter advances idx on wrap; idx wraps NDIGITS-1 -> 0.
//    DigitSel = ~(1<<idx) while valid, else all 1s. SSD slice 0 = digit idx pattern, and
//    that pattern and DigitSel update on the same edge (no ghosting). Other slices = 1111111.
//  - Width rules: counters are $clog2(DIV) bits; compare against DIV-1 (no overflow wrap).
//    Value is never truncated.
//  - Reset asserted mid-operation blanks all outputs immediately. After release, the
//    display stays blank until the next Load.
// STRUCTURE
//  - Shared include ssd_defs.vh: `SSD_BLANK 7'b1111111 and the 16 glyph constants.
//  - Sub-module hex_ssd_glyph: combinational nibble -> 7-bit glyph plus blank input.
//    Generate NDIGITS copies (static) or one copy on the idx-muxed nibble (scan).
//  - Top level: shadow regs, msd priority encoder, blink divider, scan divider/idx,
//    output regs, Ack register.
// TESTING (NDIGITS=4, SCAN_DIV=4, BLINK_DIV=8 in the bench)
//  1 Reset, no Load -> SSD=all 1s, DigitSel=1111, Ack=0. Load Value=16'h1234, all enabled
//    -> next edge SSD = {1001111,0010010,0000110,1001100} (digit3..0), Ack for one cycle.
//  2 Value=16'h00A0, BlankLZ=1 -> digits 3,2 = 1111111; digit1 = 0001000; digit0 = 0000001.
//    Value=0 -> only digit0 = 0000001.
//  3 BlinkMask=4'b0001 -> digit0 alternates glyph/1111111 every 8 clocks; others steady.
//    Load mid-phase -> period unchanged.
//  4 SCAN_MODE=1, Value=16'hF00D -> DigitSel cycles 1110,1101,1011,0111, 4 clocks each.
//    SSD slice0 tracks 1000010,0000001,0000001,0111000 on the same edges.
//  5 Load high 3 consecutive cycles with values 1,2,3 -> Ack high 3 cycles; final display 0003.
//  6 Async Reset pulse between clock edges mid-scan -> SSD all 1s and DigitSel 1111 at once.
//    The display stays blank after release until the next Load.

Source files
------------

// File: rtl/hex_ssd_bank_pkg.sv
// Shared glyph table and constants for the hex seven-segment bank.
// Glyphs are active-low {a,b,c,d,e,f,g}.
package hex_ssd_bank_pkg;

    localparam logic [6:0] SSD_BLANK = 7'b1111111;

    function automatic logic [6:0] glyph_of(input logic [3:0] h);
        logic [6:0] g;
        g = SSD_BLANK;
        case (h)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0001100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            4'hF: g = 7'b0111000;
            default: g = SSD_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_ssd_bank_if.sv
// Load/display bundle between a lab datapath and the HEX driver.
// master = datapath side, slave = driver side.
interface hex_ssd_bank_if #(
    parameter int NDIGITS = 4
);
    logic                   load;
    logic [4*NDIGITS-1:0]   value;
    logic [NDIGITS-1:0]     digit_en;
    logic [NDIGITS-1:0]     blink_mask;
    logic                   blank_lz;
    logic [7*NDIGITS-1:0]   ssd;
    logic [NDIGITS-1:0]     digit_sel;
    logic                   ack;

    modport master (
        output load, value, digit_en, blink_mask, blank_lz,
        input  ssd, digit_sel, ack
    );

    modport slave (
        input  load, value, digit_en, blink_mask, blank_lz,
        output ssd, digit_sel, ack
    );
endinterface

// File: rtl/hex_ssd_glyph.sv
// Nibble to active-low seven-segment glyph, with a blank override.
// Purely combinational; the top registers the result.
module hex_ssd_glyph (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] glyph
);
    import hex_ssd_bank_pkg::*;

    assign glyph = blank ? SSD_BLANK : glyph_of(nibble);
endmodule

// File: rtl/hex_ssd_bank.sv
// Multi-digit hex display driver: shadow regs, LZ blanking, blink,
// optional scan multiplexing, registered outputs and load ack.
module hex_ssd_bank #(
    parameter int NDIGITS   = 4,
    parameter int SCAN_MODE = 0,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input logic           clk,
    input logic           rst,
    hex_ssd_bank_if.slave bus
);
    import hex_ssd_bank_pkg::*;

    localparam int BW = $clog2(BLINK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(NDIGITS - 1);

    logic [4*NDIGITS-1:0] val_q;
    logic [NDIGITS-1:0]   en_q;
    logic [NDIGITS-1:0]   mask_q;
    logic                 lz_q;
    logic                 valid_q;
    logic                 load_q;
    logic                 ack_q;
    logic [BW-1:0]        bcnt;
    logic                 phase;
    logic [SW-1:0]        scnt;
    logic [IW-1:0]        idx;
    logic [3:0]           msd;
    logic [NDIGITS-1:0]   blank;
    logic [7*NDIGITS-1:0] ssd_d;
    logic [7*NDIGITS-1:0] ssd_q;
    logic [NDIGITS-1:0]   sel_d;
    logic [NDIGITS-1:0]   sel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q   <= '0;
            en_q    <= '0;
            mask_q  <= '0;
            lz_q    <= 1'b0;
            valid_q <= 1'b0;
        end else if (bus.load) begin
            val_q   <= bus.value;
            en_q    <= bus.digit_en;
            mask_q  <= bus.blink_mask;
            lz_q    <= bus.blank_lz;
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (bcnt == BMAX) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt <= '0;
            idx  <= '0;
        end else if (SCAN_MODE == 0) begin
            scnt <= '0;
            idx  <= '0;
        end else if (scnt == SMAX) begin
            scnt <= '0;
            idx  <= (idx == IMAX) ? '0 : idx + 1'b1;
        end else begin
            scnt <= scnt + 1'b1;
        end
    end

    always_comb begin
        msd = '0;
        for (int i = 0; i < NDIGITS; i++)
            if (val_q[4*i +: 4] != 4'd0)
                msd = 4'(i);
    end

    // digit 0 is exempt from LZ blanking so a zero value still reads "0"
    always_comb begin
        blank = '0;
        for (int i = 0; i < NDIGITS; i++)
            blank[i] = !valid_q || !en_q[i] || (mask_q[i] && phase)
                     || (lz_q && (4'(i) > msd) && (i != 0));
    end

    if (SCAN_MODE == 0) begin : g_static
        for (genvar i = 0; i < NDIGITS; i++) begin : g_dig
            hex_ssd_glyph u_glyph (
                .nibble (val_q[4*i +: 4]),
                .blank  (blank[i]),
                .glyph  (ssd_d[7*i +: 7])
            );
        end
        assign sel_d = valid_q ? '0 : '1;
    end else begin : g_scan
        logic [3:0] nib;
        logic       blk;
        logic [6:0] g;

        always_comb begin
            nib = 4'd0;
            blk = 1'b1;
            for (int i = 0; i < NDIGITS; i++)
                if (idx == IW'(i)) begin
                    nib = val_q[4*i +: 4];
                    blk = blank[i];
                end
        end

        hex_ssd_glyph u_glyph (
            .nibble (nib),
            .blank  (blk),
            .glyph  (g)
        );

        always_comb begin
            ssd_d      = '1;
            ssd_d[6:0] = g;
        end
        assign sel_d = valid_q ? ~(NDIGITS'(1) << idx) : '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ssd_q  <= '1;
            sel_q  <= '1;
            load_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            ssd_q  <= ssd_d;
            sel_q  <= sel_d;
            load_q <= bus.load;
            ack_q  <= load_q;
        end
    end

    assign bus.ssd       = ssd_q;
    assign bus.digit_sel = sel_q;
    assign bus.ack       = ack_q;
endmodule
